// File: rtl/alu_unit.sv
// Opcode set and result-entry layout shared with the issue side.
// ALU execution unit: computes one issued op per cycle into a small result FIFO drained over the CDB.
package alu_pkg;
  localparam logic [5:0] OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8;
  localparam logic [5:0] OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10, OP_ADDI  = 6'd11, OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_SLTIU = 6'd13, OP_XORI  = 6'd14, OP_ORI   = 6'd15, OP_ANDI  = 6'd16;
  localparam logic [5:0] OP_SLLI  = 6'd17, OP_SRLI  = 6'd18, OP_SRAI  = 6'd19, OP_ADD   = 6'd20;
  localparam logic [5:0] OP_SUB   = 6'd21, OP_SLL   = 6'd22, OP_SLT   = 6'd23, OP_SLTU  = 6'd24;
  localparam logic [5:0] OP_XOR   = 6'd25, OP_SRL   = 6'd26, OP_SRA   = 6'd27, OP_OR    = 6'd28;
  localparam logic [5:0] OP_AND   = 6'd29;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  rename;
    logic        is_branch;
    logic        taken;
    logic [31:0] target;
  } res_t;
endpackage

module alu_unit
  import alu_pkg::*;
#(
  parameter int RES_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic        alu_enable,
  input  logic [5:0]  to_alu_op,
  input  logic [31:0] to_alu_rs1_value,
  input  logic [31:0] to_alu_rs2_value,
  input  logic [31:0] to_alu_imm,
  input  logic [31:0] to_alu_pc,
  input  logic [4:0]  to_alu_rd_renaming,
  output logic        alu_ready,
  input  logic        cdb_grant,
  output logic        alu_broadcast,
  output logic [31:0] alu_cbd_value,
  output logic [4:0]  alu_update_rename,
  output logic        alu_is_branch,
  output logic        alu_jump_taken,
  output logic [31:0] alu_jump_target
);
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH) + 1;

  res_t             fifo [RES_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  res_t             res;
  logic             push, pop;

  logic [31:0] rs1, rs2, imm, pc, pc_imm, pc_4;
  assign rs1    = to_alu_rs1_value;
  assign rs2    = to_alu_rs2_value;
  assign imm    = to_alu_imm;
  assign pc     = to_alu_pc;
  assign pc_imm = pc + imm;
  assign pc_4   = pc + 32'd4;

  always_comb begin
    res           = '0;
    res.rename    = to_alu_rd_renaming;
    case (to_alu_op)
      OP_ADD:   res.value = rs1 + rs2;
      OP_ADDI:  res.value = rs1 + imm;
      OP_SUB:   res.value = rs1 - rs2;
      OP_AND:   res.value = rs1 & rs2;
      OP_ANDI:  res.value = rs1 & imm;
      OP_OR:    res.value = rs1 | rs2;
      OP_ORI:   res.value = rs1 | imm;
      OP_XOR:   res.value = rs1 ^ rs2;
      OP_XORI:  res.value = rs1 ^ imm;
      OP_SLL:   res.value = rs1 << rs2[4:0];
      OP_SLLI:  res.value = rs1 << imm[4:0];
      OP_SRL:   res.value = rs1 >> rs2[4:0];
      OP_SRLI:  res.value = rs1 >> imm[4:0];
      OP_SRA:   res.value = $unsigned($signed(rs1) >>> rs2[4:0]);
      OP_SRAI:  res.value = $unsigned($signed(rs1) >>> imm[4:0]);
      OP_SLT:   res.value = {31'd0, $signed(rs1) < $signed(rs2)};
      OP_SLTI:  res.value = {31'd0, $signed(rs1) < $signed(imm)};
      OP_SLTU:  res.value = {31'd0, rs1 < rs2};
      OP_SLTIU: res.value = {31'd0, rs1 < imm};
      OP_LUI:   res.value = imm;
      OP_AUIPC: res.value = pc_imm;
      OP_JAL: begin
        res.value = pc_4; res.is_branch = 1'b1; res.taken = 1'b1; res.target = pc_imm;
      end
      OP_JALR: begin
        res.value = pc_4; res.is_branch = 1'b1; res.taken = 1'b1;
        res.target = (rs1 + imm) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res.is_branch = 1'b1;
        case (to_alu_op)
          OP_BEQ:  res.taken = (rs1 == rs2);
          OP_BNE:  res.taken = (rs1 != rs2);
          OP_BLT:  res.taken = $signed(rs1) <  $signed(rs2);
          OP_BGE:  res.taken = $signed(rs1) >= $signed(rs2);
          OP_BLTU: res.taken = rs1 <  rs2;
          default: res.taken = rs1 >= rs2;
        endcase
        res.target = res.taken ? pc_imm : pc_4;
      end
      default: ;
    endcase
  end

  // Ready depends on occupancy only, so a full FIFO refuses issue even while popping.
  assign alu_ready     = (count != CNT_W'(RES_DEPTH));
  assign alu_broadcast = (count != '0);
  assign push          = alu_enable && alu_ready;
  assign pop           = alu_broadcast && cdb_grant;

  assign alu_cbd_value     = fifo[head].value;
  assign alu_update_rename = fifo[head].rename;
  assign alu_is_branch     = fifo[head].is_branch;
  assign alu_jump_taken    = fifo[head].taken;
  assign alu_jump_target   = fifo[head].target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < RES_DEPTH; i++) fifo[i] <= '0;
    end else if (rdy) begin
      if (jump_wrong) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          fifo[tail] <= res;
          tail       <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: issues push expected results, a negedge monitor checks the CDB head.
module tb_alu_unit;
  import alu_pkg::*;

  logic        clk = 0, rst = 1, rdy = 1, jump_wrong = 0, alu_enable = 0, cdb_grant = 0;
  logic [5:0]  to_alu_op = '0;
  logic [31:0] to_alu_rs1_value = '0, to_alu_rs2_value = '0, to_alu_imm = '0, to_alu_pc = '0;
  logic [4:0]  to_alu_rd_renaming = '0;
  logic        alu_ready, alu_broadcast, alu_is_branch, alu_jump_taken;
  logic [31:0] alu_cbd_value, alu_jump_target;
  logic [4:0]  alu_update_rename;

  int   total = 0, bad = 0;
  res_t exp_q[$];

  alu_unit #(.RES_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong), .alu_enable(alu_enable),
    .to_alu_op(to_alu_op), .to_alu_rs1_value(to_alu_rs1_value),
    .to_alu_rs2_value(to_alu_rs2_value), .to_alu_imm(to_alu_imm), .to_alu_pc(to_alu_pc),
    .to_alu_rd_renaming(to_alu_rd_renaming), .alu_ready(alu_ready), .cdb_grant(cdb_grant),
    .alu_broadcast(alu_broadcast), .alu_cbd_value(alu_cbd_value),
    .alu_update_rename(alu_update_rename), .alu_is_branch(alu_is_branch),
    .alu_jump_taken(alu_jump_taken), .alu_jump_target(alu_jump_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: compare head every cycle it is presented; retire it when the DUT will pop.
  always @(negedge clk) begin
    assert (!(alu_enable && !alu_ready)) else $error("issue while not ready");
    if (!rst && alu_broadcast) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL cdb_unexpected: got value=%h rename=%0d want no broadcast",
                 alu_cbd_value, alu_update_rename);
      end else begin
        if (alu_cbd_value !== exp_q[0].value || alu_update_rename !== exp_q[0].rename ||
            alu_is_branch !== exp_q[0].is_branch || alu_jump_taken !== exp_q[0].taken ||
            (exp_q[0].is_branch && alu_jump_target !== exp_q[0].target)) begin
          bad++;
          $display("FAIL cdb_head: got v=%h r=%0d br=%b tk=%b tg=%h want v=%h r=%0d br=%b tk=%b tg=%h",
                   alu_cbd_value, alu_update_rename, alu_is_branch, alu_jump_taken, alu_jump_target,
                   exp_q[0].value, exp_q[0].rename, exp_q[0].is_branch, exp_q[0].taken,
                   exp_q[0].target);
        end
        if (rdy && cdb_grant && !jump_wrong) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p, input logic [4:0] rd,
                       input logic [31:0] ev, input logic ebr, input logic etk,
                       input logic [31:0] etg);
    res_t e;
    int   n = 0;
    while (!alu_ready && n < 30) begin cyc(1); n++; end
    if (!alu_ready) begin
      bad++; total++;
      $display("FAIL issue_timeout: got ready=0 want ready=1");
    end else begin
      to_alu_op = op; to_alu_rs1_value = a; to_alu_rs2_value = b;
      to_alu_imm = im; to_alu_pc = p; to_alu_rd_renaming = rd;
      alu_enable = 1;
      @(posedge clk);
      e = '{value: ev, rename: rd, is_branch: ebr, taken: etk, target: etg};
      if (rdy && !jump_wrong) exp_q.push_back(e);
      #1 alu_enable = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    cdb_grant = 1;
    while ((exp_q.size() != 0 || alu_broadcast) && n < 50) begin cyc(1); n++; end
    total++;
    if (exp_q.size() != 0 || alu_broadcast) begin
      bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", exp_q.size());
    end
  endtask

  initial begin
    cyc(2);
    chk("reset_broadcast", 32'(alu_broadcast), 32'd0);
    chk("reset_ready", 32'(alu_ready), 32'd1);
    chk("reset_value", alu_cbd_value, 32'd0);
    chk("reset_rename", 32'(alu_update_rename), 32'd0);
    rst = 0;
    cyc(1);

    // Reset while two entries are waiting
    cdb_grant = 0;
    issue(OP_ADD, 32'd1, 32'd2, 0, 0, 5'd1, 32'd3, 0, 0, 0);
    issue(OP_ADD, 32'd3, 32'd4, 0, 0, 5'd2, 32'd7, 0, 0, 0);
    chk("full_ready_low", 32'(alu_ready), 32'd0);
    rst = 1; #1;
    exp_q.delete();
    chk("midrst_broadcast", 32'(alu_broadcast), 32'd0);
    chk("midrst_ready", 32'(alu_ready), 32'd1);
    cyc(1); rst = 0; cyc(1);
    chk("post_rst_idle", 32'(alu_broadcast), 32'd0);

    // Single ADD with grant held: one-cycle latency, popped next edge
    cdb_grant = 1;
    issue(OP_ADD, 32'h7FFFFFFF, 32'd1, 0, 0, 5'd3, 32'h80000000, 0, 0, 0);
    chk("add_broadcast", 32'(alu_broadcast), 32'd1);
    chk("add_value", alu_cbd_value, 32'h80000000);
    cyc(1);
    chk("add_popped", 32'(alu_broadcast), 32'd0);

    // Back-pressure: two held entries, third waits for first pop
    cdb_grant = 0;
    issue(OP_SUB, 32'd5, 32'd7, 0, 0, 5'd4, 32'hFFFFFFFE, 0, 0, 0);
    issue(OP_ANDI, 32'h0000F0F0, 0, 32'hFF, 0, 5'd5, 32'h000000F0, 0, 0, 0);
    chk("bp_ready_low", 32'(alu_ready), 32'd0);
    cyc(3);
    chk("bp_still_full", 32'(alu_ready), 32'd0);
    cdb_grant = 1;
    cyc(1);
    chk("bp_ready_back", 32'(alu_ready), 32'd1);
    issue(OP_SRA, 32'h80000000, 32'h24, 0, 0, 5'd6, 32'hF8000000, 0, 0, 0);
    drain();

    // Arithmetic and branch vectors through a two-deep FIFO
    issue(OP_SRL,   32'h80000000, 32'h24, 0, 0, 5'd7, 32'h08000000, 0, 0, 0);
    issue(OP_SLT,   32'hFFFFFFFF, 32'd0, 0, 0, 5'd8, 32'd1, 0, 0, 0);
    issue(OP_SLTU,  32'hFFFFFFFF, 32'd0, 0, 0, 5'd9, 32'd0, 0, 0, 0);
    issue(OP_SLLI,  32'd1, 0, 32'h1F, 0, 5'd10, 32'h80000000, 0, 0, 0);
    issue(OP_XORI,  32'hFFFF0000, 0, 32'hFFFFFFFF, 0, 5'd11, 32'h0000FFFF, 0, 0, 0);
    issue(OP_LUI,   0, 0, 32'h12345000, 0, 5'd12, 32'h12345000, 0, 0, 0);
    issue(OP_AUIPC, 0, 0, 32'h2000, 32'h1000, 5'd13, 32'h3000, 0, 0, 0);
    issue(OP_JAL,   0, 0, 32'h40, 32'h100, 5'd14, 32'h104, 1, 1, 32'h140);
    issue(OP_BLT,   32'hFFFFFFFF, 32'd0, 32'h20, 32'h100, 5'd15, 32'd0, 1, 1, 32'h120);
    issue(OP_BLTU,  32'hFFFFFFFF, 32'd0, 32'h20, 32'h100, 5'd16, 32'd0, 1, 0, 32'h104);
    issue(OP_JALR,  32'h201, 0, 32'd2, 32'h300, 5'd17, 32'h304, 1, 1, 32'h202);
    issue(OP_BEQ,   32'd5, 32'd5, 32'hFFFFFFF8, 32'h10, 5'd18, 32'd0, 1, 1, 32'h8);
    issue(OP_BGE,   32'hFFFFFFFF, 32'd0, 32'h20, 32'h100, 5'd19, 32'd0, 1, 0, 32'h104);
    issue(6'd63,    32'd9, 32'd9, 32'd9, 32'h100, 5'd20, 32'd0, 0, 0, 0);
    drain();

    // Flush with one entry held and a same-edge issue
    cdb_grant = 0;
    issue(OP_ADD, 32'd1, 32'd1, 0, 0, 5'd21, 32'd2, 0, 0, 0);
    jump_wrong = 1;
    issue(OP_ADD, 32'd2, 32'd2, 0, 0, 5'd22, 32'd4, 0, 0, 0);
    exp_q.delete();
    jump_wrong = 0;
    chk("flush_broadcast", 32'(alu_broadcast), 32'd0);
    chk("flush_ready", 32'(alu_ready), 32'd1);
    cdb_grant = 1;
    cyc(3);
    chk("flush_no_ghost", 32'(alu_broadcast), 32'd0);

    // Freeze: rdy low holds the head despite grant
    cdb_grant = 0;
    issue(OP_ORI, 32'hA0, 0, 32'h0B, 0, 5'd23, 32'hAB, 0, 0, 0);
    rdy = 0; cdb_grant = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("frz_broadcast", 32'(alu_broadcast), 32'd1);
      chk("frz_value", alu_cbd_value, 32'hAB);
    end
    rdy = 1;
    cyc(1);
    chk("frz_resume_pop", 32'(alu_broadcast), 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
